// File: rtl/mac_datapath_engine.sv
// Streaming signed multiply / multiply-accumulate datapath joining streams a/b (and c) into d.
// Optional build macro MAC_DATAPATH_ENGINE_SATURATE_EN clamps d results instead of wrapping them.
module mac_datapath_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic                  simple_mul_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic [5:0]            shift_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  c_valid_i,
    output logic                  c_ready_o,
    input  logic [DATA_WIDTH-1:0] c_data_i,
    output logic                  d_valid_o,
    input  logic                  d_ready_i,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_BIAS, S_OUT, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic                           simple_q, simple_d;
    logic [CNT_WIDTH-1:0]           len_q, len_d;
    logic [5:0]                     shift_q, shift_d;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                           s1_valid_q, s1_valid_d;
    logic signed [2*DATA_WIDTH-1:0] p_q, p_d;
    logic                           d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0]          d_data_q, d_data_d;

    logic                  d_free, s1_adv, s1_free, ab_fire, c_fire, d_fire;
    logic [DATA_WIDTH-1:0] mul_res, bias_res;

`ifdef MAC_DATAPATH_ENGINE_SATURATE_EN
    localparam logic signed [ACC_WIDTH:0] D_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] D_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] clamp(input logic signed [ACC_WIDTH:0] v);
        if (v > D_MAX)      return D_MAX[DATA_WIDTH-1:0];
        else if (v < D_MIN) return D_MIN[DATA_WIDTH-1:0];
        else                return v[DATA_WIDTH-1:0];
    endfunction

    logic signed [ACC_WIDTH:0] mul_wide, bias_wide;

    always_comb begin
        mul_wide  = (ACC_WIDTH+1)'(p_q >>> shift_q);
        bias_wide = (ACC_WIDTH+1)'(acc_q >>> shift_q) + (ACC_WIDTH+1)'($signed(c_data_i));
        mul_res   = clamp(mul_wide);
        bias_res  = clamp(bias_wide);
    end
`else
    always_comb begin
        mul_res  = DATA_WIDTH'(p_q >>> shift_q);
        bias_res = DATA_WIDTH'(acc_q >>> shift_q) + c_data_i;
    end
`endif

    // In simple mode stage1 only drains when the output register can take its result.
    always_comb begin
        d_free  = !d_valid_q || d_ready_i;
        s1_adv  = s1_valid_q && (!simple_q || d_free);
        s1_free = !s1_valid_q || s1_adv;
        ab_fire = enable_i && (state_q == S_RUN) && a_valid_i && b_valid_i &&
                  (cnt_q < len_q) && s1_free && (!simple_q || d_free);
        c_fire  = enable_i && (state_q == S_BIAS) && c_valid_i;
        d_fire  = enable_i && d_valid_q && d_ready_i;
    end

    always_comb begin
        state_d    = state_q;
        simple_d   = simple_q;
        len_d      = len_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        d_valid_d  = d_valid_q;
        d_data_d   = d_data_q;
        if (enable_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        simple_d = simple_mul_i;
                        len_d    = len_i;
                        shift_d  = shift_i;
                        cnt_d    = '0;
                        acc_d    = '0;
                        state_d  = (len_i != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (ab_fire) begin
                        p_d        = (2*DATA_WIDTH)'($signed(a_data_i)) *
                                     (2*DATA_WIDTH)'($signed(b_data_i));
                        s1_valid_d = 1'b1;
                        cnt_d      = cnt_q + CNT_WIDTH'(1);
                    end else if (s1_adv) begin
                        s1_valid_d = 1'b0;
                    end
                    if (simple_q) begin
                        if (s1_adv) begin
                            d_valid_d = 1'b1;
                            d_data_d  = mul_res;
                        end else if (d_fire) begin
                            d_valid_d = 1'b0;
                        end
                        if (cnt_q == len_q && !s1_valid_q && (!d_valid_q || d_fire))
                            state_d = S_DONE;
                    end else begin
                        if (s1_valid_q)
                            acc_d = acc_q + ACC_WIDTH'(p_q);
                        if (cnt_q == len_q && !s1_valid_q)
                            state_d = S_BIAS;
                    end
                end
                S_BIAS: begin
                    if (c_fire) begin
                        d_valid_d = 1'b1;
                        d_data_d  = bias_res;
                        state_d   = S_OUT;
                    end
                end
                S_OUT: begin
                    if (d_fire) begin
                        d_valid_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Soft clear behaves exactly like reset and drops any in-flight data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q    <= S_IDLE;
            simple_q   <= 1'b0;
            len_q      <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            d_valid_q  <= 1'b0;
            d_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            simple_q   <= simple_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            p_q        <= p_d;
            d_valid_q  <= d_valid_d;
            d_data_q   <= d_data_d;
        end
    end

    assign a_ready_o = ab_fire;
    assign b_ready_o = ab_fire;
    assign c_ready_o = enable_i && (state_q == S_BIAS);
    assign d_valid_o = d_valid_q;
    assign d_data_o  = d_data_q;
    assign busy_o    = (state_q == S_RUN) || (state_q == S_BIAS) || (state_q == S_OUT);
    assign done_o    = enable_i && (state_q == S_DONE);
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_mac_datapath_engine.sv
// Directed bench for mac_datapath_engine: table of jobs plus clear and zero-length sequences.
// Expected values follow MAC_DATAPATH_ENGINE_SATURATE_EN when the bench is built with it.
module tb_mac_datapath_engine;

    logic        clk = 1'b0;
    logic        rst_n, enable, clear, start, simple_mul;
    logic [15:0] len;
    logic [5:0]  shift;
    logic        a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, d_valid, d_ready;
    logic [31:0] a_data, b_data, c_data, d_data;
    logic        busy, done;
    logic [15:0] cnt;

    int tests = 0;
    int fails = 0;

    mac_datapath_engine dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear), .start_i(start),
        .simple_mul_i(simple_mul), .len_i(len), .shift_i(shift),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
        .c_valid_i(c_valid), .c_ready_o(c_ready), .c_data_i(c_data),
        .d_valid_o(d_valid), .d_ready_i(d_ready), .d_data_o(d_data),
        .busy_o(busy), .done_o(done), .cnt_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              simple;
        int              len;
        logic [5:0]      shift;
        logic [7:0][31:0] a;
        logic [7:0][31:0] b;
        logic [7:0][31:0] d;
        logic [31:0]     c;
        int              n_d;
        bit              toggle;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic put(input int k, input int i, input int a, input int b, input int d);
        tbl[k].a[i] = a;
        tbl[k].b[i] = b;
        tbl[k].d[i] = d;
    endtask

    task automatic cfg(input int k, input bit s, input int l, input int sh, input int c,
                       input bit tog);
        tbl[k].simple = s;
        tbl[k].len    = l;
        tbl[k].shift  = 6'(sh);
        tbl[k].c      = c;
        tbl[k].n_d    = s ? l : 1;
        tbl[k].toggle = tog;
        tbl[k].a      = '0;
        tbl[k].b      = '0;
        tbl[k].d      = '0;
    endtask

    // Called at posedge+1; drives one job until done_o or the cycle budget runs out.
    task automatic run_job(input int k);
        int ai, ci, nd, last_d, done_cyc, stall_viol;
        bit done_seen;
        ai = 0; ci = 0; nd = 0; last_d = -10; done_cyc = -1; stall_viol = 0; done_seen = 0;
        simple_mul = tbl[k].simple;
        len        = 16'(tbl[k].len);
        shift      = tbl[k].shift;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            a_valid = (ai < tbl[k].len);
            b_valid = a_valid;
            a_data  = (ai < 8) ? tbl[k].a[ai] : 32'd0;
            b_data  = (ai < 8) ? tbl[k].b[ai] : 32'd0;
            c_valid = !tbl[k].simple && (ci == 0);
            c_data  = tbl[k].c;
            d_ready = tbl[k].toggle ? cyc[0] : 1'b1;
            @(negedge clk);
            if (a_valid && a_ready) ai++;
            if (c_valid && c_ready) ci++;
            if (d_valid && !d_ready && a_ready) stall_viol++;
            if (d_valid && d_ready) begin
                if (nd < tbl[k].n_d)
                    check($sformatf("job%0d d[%0d]", k, nd), 64'(d_data), 64'(tbl[k].d[nd]));
                nd++;
                last_d = cyc;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check($sformatf("job%0d cnt_at_done", k), 64'(cnt), 64'(tbl[k].len));
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_ready = 1'b0;
        check($sformatf("job%0d done_seen", k), 64'(done_seen), 64'd1);
        check($sformatf("job%0d d_count", k), 64'(nd), 64'(tbl[k].n_d));
        check($sformatf("job%0d c_count", k), 64'(ci), tbl[k].simple ? 64'd0 : 64'd1);
        check($sformatf("job%0d ab_count", k), 64'(ai), 64'(tbl[k].len));
        check($sformatf("job%0d stall_ready", k), 64'(stall_viol), 64'd0);
        if (tbl[k].simple)
            check($sformatf("job%0d done_after_last_d", k), 64'(done_cyc - last_d), 64'd1);
        $display("[TB] job %0d simple=%0d len=%0d: %0d d words, done at cycle %0d",
                 k, tbl[k].simple, tbl[k].len, nd, done_cyc);
    endtask

    initial begin
        int n;
        bit ok;
        cfg(0, 1, 4, 0, 0, 0);
        put(0, 0, 1, 5, 5);   put(0, 1, 2, 6, 12);
        put(0, 2, -3, 7, -21); put(0, 3, 4, -8, -32);
        cfg(1, 0, 3, 2, 10, 0);
        put(1, 0, 4, 3, 19);  put(1, 1, 4, 3, 0);  put(1, 2, 4, 3, 0);
        cfg(2, 1, 8, 0, 0, 1);
        put(2, 0, 1, 10, 10);   put(2, 1, 2, -10, -20);
        put(2, 2, 3, 20, 60);   put(2, 3, 4, -20, -80);
        put(2, 4, 5, 30, 150);  put(2, 5, 6, -30, -180);
        put(2, 6, 7, 40, 280);  put(2, 7, 8, -40, -320);
        cfg(3, 0, 1, 0, 0, 0);
`ifdef MAC_DATAPATH_ENGINE_SATURATE_EN
        put(3, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
`else
        put(3, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001);
`endif
        cfg(4, 1, 2, 4, 0, 0);
        put(4, 0, -100, 3, -19); put(4, 1, 1000, 3, 187);
        cfg(5, 0, 4, 1, -5, 0);
        put(5, 0, -7, 3, -27); put(5, 1, 5, -4, 0); put(5, 2, -2, 6, 0); put(5, 3, 9, 1, 0);
        cfg(6, 0, 1, 0, 1, 0);
        put(6, 0, 2, 3, 7);

        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; start = 1'b0; simple_mul = 1'b0;
        len = '0; shift = '0; a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_ready = 1'b0;
        a_data = '0; b_data = '0; c_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset d_valid", 64'(d_valid), 64'd0);
        check("reset d_data", 64'(d_data), 64'd0);
        check("reset cnt", 64'(cnt), 64'd0);
        check("reset readys", 64'({a_ready, b_ready, c_ready}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++) begin
            run_job(k);
            @(posedge clk); #1;
        end

        // Clear in the middle of a long accumulate job.
        simple_mul = 1'b0; len = 16'd10; shift = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 32'd1; b_data = 32'd1;
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 5; cyc++) begin
            @(negedge clk);
            if (a_ready) n++;
            @(posedge clk); #1;
        end
        check("clear pairs_before", 64'(n), 64'd5);
        a_valid = 1'b0; b_valid = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear busy", 64'(busy), 64'd0);
        check("clear d_valid", 64'(d_valid), 64'd0);
        check("clear cnt", 64'(cnt), 64'd0);
        $display("[TB] clear after %0d pairs: busy=%0d d_valid=%0d", n, busy, d_valid);
        run_job(6);
        @(posedge clk); #1;

        // Zero-length job: done pulse only, no handshakes.
        simple_mul = 1'b0; len = '0; start = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; d_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if (busy || a_ready || b_ready || c_ready || d_valid) ok = 1'b0;
            check($sformatf("len0 done cycle%0d", cyc), 64'(done), (cyc == 0) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
        end
        check("len0 no_handshake", 64'(ok), 64'd1);
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_ready = 1'b0;
        $display("[TB] zero-length job: quiet=%0d", ok);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
